psram_responder: RTL and testbench

//  Synthesizable responder (device side) of the dual-chip QPI PSRAM bus driven by our PSRAM controller.

---
 rtl/psram_pkg.sv | 28 ++
 rtl/psram_resp_mem.sv | 38 +++
 rtl/psram_responder.sv | 201 ++++++++++++++++++++
 tb/tb_psram_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared PSRAM bus definitions: command opcodes, responder state encoding,
// and a lane-agreement helper used by both the responder and the controller.
package psram_pkg;

  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_WRITE     = 8'h38;
  localparam logic [7:0] CMD_READ      = 8'hEB;
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

  typedef enum logic [3:0] {
    SPI_IDLE,
    SPI_CMD,
    SPI_IGNORE,
    QPI_IDLE,
    QPI_CMD,
    QPI_ADDR,
    QPI_WDATA,
    QPI_DUMMY,
    QPI_RDATA,
    QPI_IGNORE
  } psram_state_e;

  // Both chips receive identical command/address nibbles, so the two lanes must agree.
  function automatic logic lanes_match(input logic [7:0] sio);
    return sio[7:4] == sio[3:0];
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Two-port synchronous RAM backing the responder: port A is the bus
// read/write port, port B is a read-only backdoor. Both reads are registered
// and read-first, so a same-edge write is not visible until the next read.
module psram_resp_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [15:0]          a_wdata,
  output logic [15:0]          a_rdata,
  input  logic [ADDR_BITS-1:0] b_addr,
  output logic [15:0]          b_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0] mem [DEPTH];

  // Bus port: write plus registered read of the old contents.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    a_rdata <= mem[a_addr];
  end

  // Backdoor port: registered read, output register cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata <= '0;
    end else begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/psram_responder.sv
// Device-side model of the dual-chip QPI PSRAM bus. Decodes SPI enter-QPI,
// QPI write/read/exit and serves a 16-bit word RAM, one nibble per lane per clock.
module psram_responder
  import psram_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_psram_csn,
  input  logic [7:0]           i_sio,
  output logic [7:0]           o_sio,
  output logic                 o_sio_oe,
  output logic                 o_qpi_mode,
  output logic [3:0]           o_state,
  output logic                 o_wr_pulse,
  output logic                 o_err,
  input  logic [ADDR_BITS-1:0] i_bd_addr,
  output logic [15:0]          o_bd_data
);

  localparam logic [3:0] DUMMY_LAST = 4'(WAIT_CYCLES - 1);

  psram_state_e         state_q, state_d;
  logic                 qpi_q, qpi_d;
  logic [7:0]           sio_q, sio_d;
  logic                 oe_q, oe_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic                 err_q, err_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [3:0]           dummy_q, dummy_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           hi_q, hi_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;

  psram_resp_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .a_we    (mem_we),
    .a_addr  (mem_addr),
    .a_wdata (mem_wdata),
    .a_rdata (mem_rdata),
    .b_addr  (i_bd_addr),
    .b_rdata (o_bd_data)
  );

  // Next-state logic for the bus FSM, shift/address registers and RAM port A.
  always_comb begin
    state_d    = state_q;
    qpi_d      = qpi_q;
    sio_d      = sio_q;
    oe_d       = oe_q;
    wr_pulse_d = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    dummy_d    = dummy_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    mem_we     = 1'b0;
    mem_wdata  = {hi_q, i_sio};

    if (i_psram_csn) begin
      // Deselect ends any transaction; an unpaired write byte is simply forgotten.
      state_d = qpi_q ? QPI_IDLE : SPI_IDLE;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SPI_IDLE: begin
          cmd_d   = {7'd0, i_sio[1]};
          cnt_d   = 3'd1;
          state_d = SPI_CMD;
          if (i_sio[5] != i_sio[1]) err_d = 1'b1;
        end
        SPI_CMD: begin
          cmd_d = {cmd_q[6:0], i_sio[1]};
          cnt_d = cnt_q + 3'd1;
          if (i_sio[5] != i_sio[1]) err_d = 1'b1;
          if (cnt_q == 3'd7) begin
            if (cmd_d == CMD_QPI_ENTER) begin
              qpi_d   = 1'b1;
              state_d = QPI_IGNORE;
            end else begin
              state_d = SPI_IGNORE;
            end
          end
        end
        QPI_IDLE: begin
          cmd_d   = {4'd0, i_sio[3:0]};
          state_d = QPI_CMD;
          if (!lanes_match(i_sio)) err_d = 1'b1;
        end
        QPI_CMD: begin
          cmd_d = {cmd_q[3:0], i_sio[3:0]};
          if (!lanes_match(i_sio)) err_d = 1'b1;
          if (cmd_d == CMD_WRITE || cmd_d == CMD_READ) begin
            cnt_d   = '0;
            state_d = QPI_ADDR;
          end else begin
            if (cmd_d == CMD_QPI_EXIT) qpi_d = 1'b0;
            state_d = QPI_IGNORE;
          end
        end
        QPI_ADDR: begin
          // Shifting straight into the word address drops high bits, giving aliasing.
          addr_d = ADDR_BITS'({addr_q, i_sio[3:0]});
          cnt_d  = cnt_q + 3'd1;
          if (!lanes_match(i_sio)) err_d = 1'b1;
          if (cnt_q == 3'd5) begin
            cnt_d   = '0;
            dummy_d = '0;
            state_d = (cmd_q == CMD_WRITE) ? QPI_WDATA : QPI_DUMMY;
          end
        end
        QPI_WDATA: begin
          if (!cnt_q[0]) begin
            hi_d  = i_sio;
            cnt_d = 3'd1;
          end else begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
            addr_d     = addr_q + 1'b1;
            cnt_d      = '0;
          end
        end
        QPI_DUMMY: begin
          dummy_d = dummy_q + 4'd1;
          if (dummy_q == DUMMY_LAST) begin
            oe_d    = 1'b1;
            sio_d   = mem_rdata[15:8];
            cnt_d   = '0;
            state_d = QPI_RDATA;
          end
        end
        QPI_RDATA: begin
          if (!cnt_q[0]) begin
            sio_d = mem_rdata[7:0];
            cnt_d = 3'd1;
          end else begin
            sio_d  = mem_rdata[15:8];
            addr_d = addr_q + 1'b1;
            cnt_d  = '0;
          end
        end
        default: ;
      endcase
    end

    // RAM address: the word being assembled (so the read starts on the last
    // address edge), the write target, or one word ahead while streaming reads.
    case (state_q)
      QPI_RDATA: mem_addr = addr_q + 1'b1;
      QPI_WDATA: mem_addr = addr_q;
      default:   mem_addr = addr_d;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SPI_IDLE;
      qpi_q      <= 1'b0;
      sio_q      <= '0;
      oe_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      dummy_q    <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      qpi_q      <= qpi_d;
      sio_q      <= sio_d;
      oe_q       <= oe_d;
      wr_pulse_q <= wr_pulse_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      dummy_q    <= dummy_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
    end
  end

  assign o_sio      = sio_q;
  assign o_sio_oe   = oe_q;
  assign o_qpi_mode = qpi_q;
  assign o_state    = state_q;
  assign o_wr_pulse = wr_pulse_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_psram_responder.sv
// Randomized scoreboard bench for psram_responder: a word-array model predicts
// read bytes and write pulses; a monitor consumes DUT output independently.
module tb_psram_responder;
  import psram_pkg::*;

  localparam int AB    = 10;
  localparam int W     = 7;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csn = 1'b1;
  logic [7:0]    sio_in = '0;
  logic [AB-1:0] bd_addr = '0;
  logic [7:0]    o_sio;
  logic          o_sio_oe, o_qpi_mode, o_wr_pulse, o_err;
  logic [3:0]    o_state;
  logic [15:0]   o_bd_data;

  psram_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_psram_csn (csn),
    .i_sio       (sio_in),
    .o_sio       (o_sio),
    .o_sio_oe    (o_sio_oe),
    .o_qpi_mode  (o_qpi_mode),
    .o_state     (o_state),
    .o_wr_pulse  (o_wr_pulse),
    .o_err       (o_err),
    .i_bd_addr   (bd_addr),
    .o_bd_data   (o_bd_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] model_mem [DEPTH];
  int          exp_wr = 0;
  int          seen_wr = 0;
  logic [7:0]  rd_q [$];
  logic [15:0] wq [$];
  logic [7:0]  exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: counts write pulses and checks every driven read byte against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_wr_pulse) seen_wr++;
        if (o_sio_oe) begin
          if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: DUT drove %02h with no byte expected", o_sio);
          end else begin
            exp_b = rd_q.pop_front();
            chk("rd_byte", 32'(o_sio), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    csn    = 1'b0;
    sio_in = {n, n};
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    csn    = 1'b0;
    sio_in = b;
  endtask

  task automatic end_xfer();
    @(negedge clk);
    csn    = 1'b1;
    sio_in = '0;
    @(negedge clk);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
  endtask

  task automatic spi_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      csn       = 1'b0;
      sio_in    = '0;
      sio_in[1] = c[i];
      sio_in[5] = c[i];
    end
    end_xfer();
    $display("spi cmd %02h", c);
  endtask

  // Writes the words queued in wq starting at address a.
  task automatic qpi_write(input logic [23:0] a);
    nib(4'h3); nib(4'h8);
    send_addr(a);
    for (int i = 0; i < wq.size(); i++) begin
      put_byte(wq[i][15:8]);
      put_byte(wq[i][7:0]);
      model_mem[(int'(a[AB-1:0]) + i) % DEPTH] = wq[i];
      exp_wr++;
    end
    end_xfer();
    chk("wr_pulses", seen_wr, exp_wr);
    $display("qpi write addr %06h words %0d", a, wq.size());
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(model_mem[(int'(a[AB-1:0]) + i) % DEPTH][15:8]);
      rd_q.push_back(model_mem[(int'(a[AB-1:0]) + i) % DEPTH][7:0]);
    end
    nib(4'hE); nib(4'hB);
    send_addr(a);
    repeat (W + 2*n - 1) begin
      @(negedge clk);
      sio_in = '0;
    end
    end_xfer();
    chk("rd_drained", rd_q.size(), 0);
    chk("oe_after_read", 32'(o_sio_oe), 0);
    $display("qpi read addr %06h words %0d", a, n);
  endtask

  task automatic bd_check(input logic [AB-1:0] a);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    chk($sformatf("bd[%03h]", a), 32'(o_bd_data), 32'(model_mem[a]));
  endtask

  task automatic reset_checks();
    chk("rst_oe", 32'(o_sio_oe), 0);
    chk("rst_sio", 32'(o_sio), 0);
    chk("rst_qpi", 32'(o_qpi_mode), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_wr_pulse", 32'(o_wr_pulse), 0);
    chk("rst_state", 32'(o_state), 32'(SPI_IDLE));
    chk("rst_bd", 32'(o_bd_data), 0);
  endtask

  initial begin
    logic [23:0] ra;
    int          rn;

    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Enter QPI over SPI.
    spi_cmd(CMD_QPI_ENTER);
    chk("qpi_entered", 32'(o_qpi_mode), 1);
    chk("err_clean", 32'(o_err), 0);

    // Single write then read back over bus and backdoor.
    wq.delete(); wq.push_back(16'hA5C3);
    qpi_write(24'h000012);
    bd_check(10'h012);
    qpi_read(24'h000012, 1);

    // Fill whole RAM so every later read has a known value.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(16'($urandom));
    qpi_write(24'h000000);

    // Burst across the top of the address space.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    qpi_write(24'h0003FE);
    qpi_read(24'h0003FE, 4);
    bd_check(10'h000);
    bd_check(10'h001);
    bd_check(10'h3FF);

    // Deselect after the first data byte: no commit.
    wq.delete(); wq.push_back(16'h1111);
    qpi_write(24'h000020);
    nib(4'h3); nib(4'h8);
    send_addr(24'h000020);
    put_byte(8'hAB);
    end_xfer();
    chk("partial_no_pulse", seen_wr, exp_wr);
    bd_check(10'h020);

    // Random mix, including high address bits that must alias.
    for (int k = 0; k < 40; k++) begin
      ra = 24'($urandom);
      rn = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < rn; i++) wq.push_back(16'($urandom));
        qpi_write(ra);
      end else begin
        qpi_read(ra, rn);
      end
    end

    // Lane mismatch on the last address nibble: error, low lane used.
    chk("err_before_mismatch", 32'(o_err), 0);
    nib(4'h3); nib(4'h8);
    nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h4);
    put_byte(8'hF0);
    put_byte(8'h12); put_byte(8'h34);
    end_xfer();
    model_mem[10'h040] = 16'h1234;
    exp_wr++;
    chk("err_set", 32'(o_err), 1);
    chk("mismatch_pulse", seen_wr, exp_wr);
    bd_check(10'h040);
    wq.delete(); wq.push_back(16'h0BEE);
    qpi_write(24'h000041);
    chk("err_sticky", 32'(o_err), 1);

    // Exit QPI, ignore an unknown SPI command, re-enter.
    nib(4'hF); nib(4'h5);
    end_xfer();
    chk("qpi_exited", 32'(o_qpi_mode), 0);
    spi_cmd(8'h9F);
    chk("spi_other_cmd", 32'(o_qpi_mode), 0);
    spi_cmd(CMD_QPI_ENTER);
    chk("qpi_reentered", 32'(o_qpi_mode), 1);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 2; i++) begin
      rd_q.push_back(model_mem[(10'h3FE + i) % DEPTH][15:8]);
      rd_q.push_back(model_mem[(10'h3FE + i) % DEPTH][7:0]);
    end
    nib(4'hE); nib(4'hB);
    send_addr(24'h0003FE);
    repeat (W + 2) @(negedge clk);
    chk("mid_read_oe", 32'(o_sio_oe), 1);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    chk("mid_read_popped", rd_q.size(), 2);
    rd_q.delete();
    @(negedge clk);
    csn   = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset during read");

    // RAM survives reset.
    spi_cmd(CMD_QPI_ENTER);
    qpi_read(24'h0003FE, 2);
    qpi_read(24'h000040, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
